// File: rtl/otter_intc_pkg.sv
// Shared definitions for the otter_intc interrupt controller: register offsets,
// CTRL bit positions and the claim-id width helper.
package otter_intc_pkg;

    localparam logic [3:0] INTC_PENDING = 4'h0;
    localparam logic [3:0] INTC_ENABLE  = 4'h4;
    localparam logic [3:0] INTC_CTRL    = 4'h8;
    localparam logic [3:0] INTC_CLAIM   = 4'hC;

    localparam int unsigned INTC_CTRL_GIE = 0;

    // Claim ids run 0..n_src, so they need enough bits to hold n_src itself.
    function automatic int unsigned intc_id_width(input int unsigned n_src);
        return $clog2(n_src + 1);
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: o_id = 1 + index of the lowest set request bit,
// 0 when no request is set.
module intc_prio_enc
    import otter_intc_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = intc_id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    always_comb begin
        o_id = '0;
        // Walk downward so the lowest set index is the final assignment.
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (i_req[i-1]) begin
                o_id = ID_W'(i);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/otter_intc.sv
// Edge-triggered interrupt controller on the otter iobus. Optional feature macro:
// INTC_SYNC_EN adds a 2-flop synchronizer on irq ahead of the edge detector.
module otter_intc
    import otter_intc_pkg::*;
#(
    parameter int unsigned N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic [31:0]      iobus_addr,
    input  logic [31:0]      iobus_out,
    input  logic             iobus_wr,
    output logic [31:0]      intc_rdata,
    output logic             intrpt
);

    localparam int unsigned ID_W = intc_id_width(N_SRC);

    logic [N_SRC-1:0] w_irq_s;
    logic [N_SRC-1:0] r_irq_prev;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic             r_gie;
    logic             r_intrpt;
    logic [31:0]      r_rdata;

    logic             w_in_win;
    logic             w_wr_pend;
    logic             w_wr_en;
    logic             w_wr_ctrl;
    logic             w_wr_claim;
    logic [N_SRC-1:0] w_clr;
    logic [31:0]      w_rd_data;
    logic             w_claim_valid;
    logic [ID_W-1:0]  w_claim_id;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_s = r_sync2;
`else
    assign w_irq_s = irq;
`endif

    assign w_edge = w_irq_s & ~r_irq_prev;

    assign w_in_win   = (iobus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_pend  = iobus_wr && w_in_win && (iobus_addr[3:0] == INTC_PENDING);
    assign w_wr_en    = iobus_wr && w_in_win && (iobus_addr[3:0] == INTC_ENABLE);
    assign w_wr_ctrl  = iobus_wr && w_in_win && (iobus_addr[3:0] == INTC_CTRL);
    assign w_wr_claim = iobus_wr && w_in_win && (iobus_addr[3:0] == INTC_CLAIM);

    intc_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio (
        .i_req   (r_pending & r_enable),
        .o_valid (w_claim_valid),
        .o_id    (w_claim_id)
    );

    // Bits to clear this cycle: W1C mask, or a single bit selected by a claim id.
    always_comb begin
        w_clr = '0;
        if (w_wr_pend) begin
            w_clr = iobus_out[N_SRC-1:0];
        end else if (w_wr_claim) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (iobus_out == 32'(i + 1)) begin
                    w_clr[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_in_win) begin
            case (iobus_addr[3:0])
                INTC_PENDING: w_rd_data = {{(32-N_SRC){1'b0}}, r_pending};
                INTC_ENABLE:  w_rd_data = {{(32-N_SRC){1'b0}}, r_enable};
                INTC_CTRL:    w_rd_data = {31'b0, r_gie};
                INTC_CLAIM:   w_rd_data = {{(32-ID_W){1'b0}}, w_claim_id};
                default:      w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_enable   <= '0;
            r_gie      <= 1'b0;
            r_intrpt   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_irq_prev <= w_irq_s;
            // A new edge overrides a same-cycle clear of the same bit.
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            if (w_wr_en) begin
                r_enable <= iobus_out[N_SRC-1:0];
            end
            if (w_wr_ctrl) begin
                r_gie <= iobus_out[INTC_CTRL_GIE];
            end
            r_intrpt   <= r_gie & w_claim_valid;
            r_rdata    <= w_rd_data;
        end
    end

    assign intc_rdata = r_rdata;
    assign intrpt     = r_intrpt;

endmodule
